complex_nr_mult_initiator: RTL
==============================

# complex_nr_mult_initiator

Hardware transaction initiator for the complex-number multiplier: the requester end of its operand/result handshake. Buffers operand packets from a host-side stream, issues them on the multiplier's `op_*` interface, accepts results on `res_*`, and hands them back to the host in order. It also bounds in-flight transactions and generates the multiplier's `sw_rst` on a host flush request. It sits between a host/register interface and one multiplier instance.

## Interface
- `DATA_WIDTH`, 8, width of one real or imaginary operand component (signed two's complement)
- `FIFO_DEPTH`, 4, entries in each of the operand and result FIFOs (power of 2, ≥2)
- `MAX_OUTSTANDING`, 2, maximum issued-but-unreturned transactions (1..FIFO_DEPTH)
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  one-cycle request: drop all buffered/in-flight work, pulse `sw_rst`
- `cmd_val`  in  1  host operand packet valid
- `cmd_ready`  out  1  operand FIFO not full and not flushing
- `cmd_data`  in  4*DATA_WIDTH  {a_re, a_im, b_re, b_im}, MSB first
- `op_val`  out  1  operand valid to multiplier
- `op_ready`  in  1  multiplier accepts operand
- `op_data`  out  4*DATA_WIDTH  operand packet, same packing as `cmd_data`
- `res_val`  in  1  multiplier result valid
- `res_ready`  out  1  initiator accepts result
- `res_data`  in  4*DATA_WIDTH  {re, im}, each 2*DATA_WIDTH signed
- `sw_rst`  out  1  soft reset to multiplier
- `rd_val`  out  1  result available to host
- `rd_ready`  in  1  host consumes result
- `rd_data`  out  4*DATA_WIDTH  result packet, unchanged from `res_data`
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
- `err_unexp`  out  1  sticky: result arrived with `outstanding`==0

## Operation
- States: IDLE (operand FIFO empty, outstanding 0), RUN (work pending), FLUSH (two cycles).
- IDLE→RUN when operand FIFO non-empty; RUN→IDLE when operand FIFO empty and outstanding 0; any state→FLUSH on `flush`; FLUSH→IDLE after 2 cycles.
- Issue: `op_val` = operand FIFO non-empty AND outstanding + (reserved for result FIFO) < limits AND state≠FLUSH. `op_data` = FIFO head. Pop on `op_val & op_ready`; outstanding +1.
- Result-space rule: issue only if (outstanding + result FIFO count) < FIFO_DEPTH, so every returned result has a slot; `res_ready` is therefore 1 whenever state≠FLUSH.
- Retire: on `res_val & res_ready` push `res_data` into result FIFO; outstanding −1. Issue and retire in the same cycle: outstanding unchanged.
- `res_val & res_ready` with outstanding 0: result dropped, `err_unexp` set; cleared only by `rst`.
- Host side: `cmd_ready` = operand FIFO not full and state≠FLUSH; `rd_val` = result FIFO non-empty. Simultaneous push/pop on a full FIFO allowed for result FIFO (pop frees slot same cycle); operand FIFO full blocks push regardless.
- FLUSH: cycle 1 `sw_rst`=1, both FIFOs emptied, outstanding cleared; cycle 2 `sw_rst`=0, all handshakes held low. `flush` during FLUSH ignored. Results arriving during FLUSH discarded, not counted as errors.
- Ordering: results returned to host in issue order; data never modified.

## Timing
- Reset (`rst`=1 at a rising edge): state IDLE, FIFOs empty, `outstanding`=0, `err_unexp`=0, `op_val`=0, `rd_val`=0, `sw_rst`=0, `cmd_ready`=1 and `res_ready`=1 from the first cycle after reset. `rst` overrides `flush`.
- Operand pushed at edge N is visible on `op_val`/`op_data` after edge N (1-cycle FIFO latency). Result accepted at edge M drives `rd_val` after edge M.
- All outputs registered or driven from registered state only; no combinational path from `op_ready`/`rd_ready` to any output.
- `op_data` stable while `op_val`=1 and `op_ready`=0.

## Structure
- Shared package `complex_mult_pkg`: field offsets for the operand/result packing, state encoding (IDLE/RUN/FLUSH).
- One sub-module `sync_fifo` (params width, depth; push/pop/full/empty/count), instantiated twice.

## Test plan
- Single transaction: cmd {3,4,1,2}, multiplier stub returns {−5,10} → `op_data`=that packet one cycle after push, `rd_data` = {−5,10}, outstanding returns 0.
- Back-pressure: `op_ready`=0 for 10 cycles with 4 cmds queued → `op_data` stable, `cmd_ready`=0 after the 4th push, no loss when released.
- Outstanding limit: multiplier stub delays results 20 cycles → `outstanding` never exceeds 2, a 3rd `op_val` only after first retire.
- Result FIFO full: `rd_ready`=0, 6 cmds → issue stops at 4 outstanding+stored, resumes exactly one slot per host read, order preserved.
- Flush mid-stream: 2 in flight, 2 queued, `flush` → `sw_rst` high exactly 1 cycle, FIFOs empty, outstanding 0, late `res_val` ignored with `err_unexp`=0.
- Spurious result: `res_val` with nothing issued → `err_unexp`=1 and stays 1 until `rst`; `rd_val` stays 0.

Source files
------------

// File: rtl/complex_mult_pkg.sv
// Shared definitions for the complex-multiplier initiator: packet field layout
// and the initiator state encoding.
package complex_mult_pkg;

  // Operand packet {a_re, a_im, b_re, b_im}: field index counted from the LSB,
  // each field DATA_WIDTH wide.
  localparam int OP_A_RE_IDX = 3;
  localparam int OP_A_IM_IDX = 2;
  localparam int OP_B_RE_IDX = 1;
  localparam int OP_B_IM_IDX = 0;

  // Result packet {re, im}: field index counted from the LSB, each 2*DATA_WIDTH wide.
  localparam int RES_RE_IDX = 1;
  localparam int RES_IM_IDX = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  function automatic int field_lsb(input int idx, input int field_w);
    return idx * field_w;
  endfunction

endpackage

// File: rtl/complex_nr_mult_initiator_sync_fifo.sv
// Synchronous FIFO with registered head, occupancy count and synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/complex_nr_mult_initiator.sv
// Requester side of the complex multiplier handshake: buffers host operands,
// bounds in-flight work, returns results in order and sequences soft flushes.
module complex_nr_mult_initiator
  import complex_mult_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 cmd_val,
  output logic                                 cmd_ready,
  input  logic [4*DATA_WIDTH-1:0]              cmd_data,
  output logic                                 op_val,
  input  logic                                 op_ready,
  output logic [4*DATA_WIDTH-1:0]              op_data,
  input  logic                                 res_val,
  output logic                                 res_ready,
  input  logic [4*DATA_WIDTH-1:0]              res_data,
  output logic                                 sw_rst,
  output logic                                 rd_val,
  input  logic                                 rd_ready,
  output logic [4*DATA_WIDTH-1:0]              rd_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_unexp
);

  localparam int PW = 4 * DATA_WIDTH;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state_q, state_d;
  logic          flush2_q, flush2_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic          err_q, err_d;

  logic [PW-1:0] op_head, res_head;
  logic          op_full, op_empty, res_full, res_empty;
  logic [CW-1:0] op_count, res_count;

  logic in_flush, flush_start, issue_ok;
  logic cmd_fire, op_fire, res_fire, res_take, rd_fire;

  assign in_flush    = (state_q == ST_FLUSH);
  assign flush_start = flush && !in_flush;

  // An operand may only leave if its eventual result already has a reserved
  // slot in the result FIFO, so res_ready never has to drop outside a flush.
  assign issue_ok = !op_empty && !res_full && !in_flush
                    && (int'(outstanding_q) < MAX_OUTSTANDING)
                    && ((int'(outstanding_q) + int'(res_count)) < FIFO_DEPTH);

  assign op_val      = issue_ok;
  assign op_data     = op_head;
  assign cmd_ready   = !op_full && !in_flush;
  assign res_ready   = !in_flush;
  assign rd_val      = !res_empty && !in_flush;
  assign rd_data     = res_head;
  assign sw_rst      = in_flush && !flush2_q;
  assign outstanding = outstanding_q;
  assign err_unexp   = err_q;

  assign cmd_fire = cmd_val && cmd_ready;
  assign op_fire  = op_val && op_ready;
  assign res_fire = res_val && res_ready;
  assign res_take = res_fire && (outstanding_q != '0);
  assign rd_fire  = rd_val && rd_ready;

  always_comb begin
    state_d  = state_q;
    flush2_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_count != '0) state_d = ST_RUN;
      end
      ST_RUN: begin
        if ((op_count == '0) && (outstanding_q == '0)) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        flush2_d = 1'b1;
        if (flush2_q) begin
          state_d  = ST_IDLE;
          flush2_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_start) begin
      state_d  = ST_FLUSH;
      flush2_d = 1'b0;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (op_fire && !res_take) begin
      outstanding_d = outstanding_q + OW'(1);
    end else if (!op_fire && res_take) begin
      outstanding_d = outstanding_q - OW'(1);
    end
    if (flush_start) outstanding_d = '0;
    err_d = err_q || (res_fire && (outstanding_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      flush2_q      <= 1'b0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush2_q      <= flush2_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_op_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (flush_start),
    .push_i  (cmd_fire),
    .pop_i   (op_fire),
    .wdata_i (cmd_data),
    .rdata_o (op_head),
    .full_o  (op_full),
    .empty_o (op_empty),
    .count_o (op_count)
  );

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (flush_start),
    .push_i  (res_take),
    .pop_i   (rd_fire),
    .wdata_i (res_data),
    .rdata_o (res_head),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_count)
  );

endmodule
